// File: rtl/bird_motion_controller.sv
// Bird vertical motion and game-phase sequencer: per-frame gravity/flap physics,
// ceiling/floor clamping, and the IDLE/PLAYING/DYING/DEAD state machine.
module bird_motion_controller #(
  parameter int SCREEN_HEIGHT  = 480,
  parameter int BIRD_HEIGHT    = 35,
  parameter int START_Y        = 200,
  parameter int GRAVITY        = 1,
  parameter int FLAP_VELOCITY  = 8,
  parameter int MAX_FALL_SPEED = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        flap,
  input  logic        collision,
  output logic [31:0] bird_top_edge,
  output logic [7:0]  velocity,
  output logic [1:0]  game_state,
  output logic        update_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    DYING   = 2'd2,
    DEAD    = 2'd3
  } state_t;

  localparam logic signed [10:0] FLOOR_S    = 11'(SCREEN_HEIGHT - BIRD_HEIGHT);
  localparam logic signed [10:0] GRAVITY_S  = 11'(GRAVITY);
  localparam logic signed [10:0] FLAP_S     = 11'(FLAP_VELOCITY);
  localparam logic signed [10:0] MAX_FALL_S = 11'(MAX_FALL_SPEED);
  localparam logic [8:0]         START_POS  = 9'(START_Y);

  state_t            state_q, state_d;
  logic [8:0]        pos_q, pos_d;
  logic signed [7:0] vel_q, vel_d;
  logic              flap_p1;
  logic              flap_pending;
  logic              flap_edge;
  logic              flap_any;
  logic              flap_eff;
  logic              do_update;
  logic signed [10:0] vel_ext;
  logic signed [10:0] vel_cand;
  logic signed [10:0] pos_next;

  // Downward speed cap; upward speeds pass through untouched.
  function automatic logic signed [10:0] sat_fall(input logic signed [10:0] v);
    if (v > MAX_FALL_S) return MAX_FALL_S;
    return v;
  endfunction

  assign flap_edge = flap & ~flap_p1;
  assign flap_any  = flap_pending | flap_edge;
  // A flap only counts when starting from IDLE or while alive and not colliding.
  assign flap_eff  = flap_any & ((state_q == IDLE) | ((state_q == PLAYING) & ~collision));

  assign vel_ext  = {{3{vel_q[7]}}, vel_q};
  assign vel_cand = flap_eff ? -FLAP_S : sat_fall(vel_ext + GRAVITY_S);
  assign pos_next = $signed({2'b00, pos_q}) + vel_cand;

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    vel_d     = vel_q;
    do_update = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_tick && flap_any) begin
          state_d   = PLAYING;
          do_update = 1'b1;
        end
      end
      PLAYING: begin
        if (collision) state_d = DYING;
        do_update = frame_tick;
      end
      DYING: begin
        do_update = frame_tick;
      end
      DEAD: begin
        if (frame_tick && flap_any) begin
          state_d = IDLE;
          pos_d   = START_POS;
          vel_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Floor hit overrides whatever state transition was chosen above.
    if (do_update) begin
      if (pos_next < 11'sd0) begin
        pos_d = '0;
        vel_d = '0;
      end else if (pos_next >= FLOOR_S) begin
        pos_d   = FLOOR_S[8:0];
        vel_d   = '0;
        state_d = DEAD;
      end else begin
        pos_d = pos_next[8:0];
        vel_d = vel_cand[7:0];
      end
    end
  end

  // Registered state, physics and flap tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pos_q        <= START_POS;
      vel_q        <= '0;
      flap_p1      <= 1'b0;
      flap_pending <= 1'b0;
      update_done  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      vel_q        <= vel_d;
      flap_p1      <= flap;
      flap_pending <= frame_tick ? 1'b0 : (flap_pending | flap_edge);
      update_done  <= frame_tick;
    end
  end

  assign bird_top_edge = {23'd0, pos_q};
  assign velocity      = vel_q;
  assign game_state    = state_q;

endmodule

// File: tb/tb_bird_motion_controller.sv
// Directed bench for bird_motion_controller: a behavioural model pushes expected
// post-tick results to a queue; a monitor pops them on every update_done pulse.
module tb_bird_motion_controller;

  logic        clk = 1'b0;
  logic        reset, frame_tick, flap, collision;
  logic [31:0] bird_top_edge;
  logic [7:0]  velocity;
  logic [1:0]  game_state;
  logic        update_done;

  bird_motion_controller dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .flap(flap),
    .collision(collision), .bird_top_edge(bird_top_edge), .velocity(velocity),
    .game_state(game_state), .update_done(update_done)
  );

  always #5 clk = ~clk;

  typedef struct { int pos; int vel; int st; } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  // Reference model state
  int m_pos = 200, m_vel = 0, m_st = 0;
  bit m_pend = 0, m_prev = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (update_done === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_update_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pos", int'(bird_top_edge), e.pos);
        chk("sb_vel", int'($signed(velocity)), e.vel);
        chk("sb_state", int'(game_state), e.st);
      end
    end
  end

  task automatic m_update(input bit fl);
    int nv, np;
    nv = fl ? -8 : ((m_vel + 1 > 10) ? 10 : m_vel + 1);
    np = m_pos + nv;
    if (np < 0) begin
      m_pos = 0; m_vel = 0;
    end else if (np >= 445) begin
      m_pos = 445; m_vel = 0; m_st = 3;
    end else begin
      m_pos = np; m_vel = nv;
    end
  endtask

  // One clock with the given inputs; the model advances in step.
  task automatic cycle(input bit t, input bit f, input bit c);
    bit edge_, any_;
    exp_t e;
    reset = 1'b0; frame_tick = t; flap = f; collision = c;
    edge_ = f && !m_prev;
    any_  = m_pend || edge_;
    m_prev = f;
    case (m_st)
      0: if (t && any_) begin m_st = 1; m_update(1'b1); end
      1: begin
        if (c) m_st = 2;
        if (t) m_update(any_ && !c);
      end
      2: if (t) m_update(1'b0);
      default: if (t && any_) begin m_st = 0; m_pos = 200; m_vel = 0; end
    endcase
    m_pend = t ? 1'b0 : (m_pend | edge_);
    if (t) begin
      e.pos = m_pos; e.vel = m_vel; e.st = m_st;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic tick_plain();
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick_flap();
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick_flap_same();
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_out(input string tag, input int pos, input int vel, input int st);
    chk({tag, "_pos"}, int'(bird_top_edge), pos);
    chk({tag, "_vel"}, int'($signed(velocity)), vel);
    chk({tag, "_state"}, int'(game_state), st);
  endtask

  task automatic fall_to_dead(input string tag, input bit flapping);
    int n = 0;
    while (game_state !== 2'd3 && n < 80) begin
      if (flapping) tick_flap(); else tick_plain();
      n++;
    end
    if (n >= 80) chk({tag, "_timeout"}, n, 0);
    chk_out(tag, 445, 0, 3);
  endtask

  task automatic do_reset();
    reset = 1'b1; frame_tick = 1'b1; flap = 1'b0; collision = 1'b0;
    m_pos = 200; m_vel = 0; m_st = 0; m_pend = 0; m_prev = 0;
    @(posedge clk); #1;
    reset = 1'b0; frame_tick = 1'b0;
  endtask

  initial begin
    int d0;
    reset = 1'b1; frame_tick = 1'b0; flap = 1'b0; collision = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk_out("reset", 200, 0, 0);
    chk("reset_done", int'(update_done), 0);

    // Idle hold
    d0 = done_cnt;
    repeat (10) tick_plain();
    chk_out("idle", 200, 0, 0);
    chk("idle_pulses", done_cnt - d0, 10);

    // Start with a separate flap edge, then coast
    tick_flap();
    chk_out("start", 192, -8, 1);
    tick_plain();
    chk_out("coast1", 185, -7, 1);
    tick_plain();
    chk_out("coast2", 179, -6, 1);

    // Free fall to the floor, then stays put
    fall_to_dead("floor", 1'b0);
    tick_plain();
    tick_plain();
    chk_out("floor_hold", 445, 0, 3);

    // Restart, then same-cycle flap start and ceiling clamp
    tick_flap();
    chk_out("restart", 200, 0, 0);
    tick_flap_same();
    chk_out("start_same", 192, -8, 1);
    repeat (24) tick_flap_same();
    chk_out("ceil_reach", 0, -8, 1);
    tick_flap_same();
    chk_out("ceil_clamp", 0, 0, 1);

    // Collision off-tick: one-cycle latency, flaps ignored while dying
    cycle(1'b0, 1'b0, 1'b1);
    chk("coll_state", int'(game_state), 2);
    tick_flap();
    chk_out("dying_noflap", 1, 1, 2);
    fall_to_dead("dying_floor", 1'b1);

    // Collision coincident with a flap tick
    tick_flap();
    chk_out("restart2", 200, 0, 0);
    tick_flap();
    chk_out("start2", 192, -8, 1);
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    chk_out("coll_tick", 185, -7, 2);
    fall_to_dead("coll_floor", 1'b0);

    // Reset mid-play, coincident with a tick
    tick_flap();
    tick_flap();
    tick_plain();
    chk("pre_reset_state", int'(game_state), 1);
    do_reset();
    chk_out("reset_tick", 200, 0, 0);
    chk("reset_tick_done", int'(update_done), 0);
    @(posedge clk); #1;

    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
